chan_550_packet_bin_loader: RTL

//  Consumes the 32-bit load_bins software register word (user_clk domain) and turns each command into

---
 rtl/chan_550_packet_bin_loader_pkg.sv | 25 ++
 rtl/chan_550_packet_bin_loader_if.sv | 21 ++
 rtl/chan_550_packet_bin_loader_edge.sv | 37 +++
 rtl/chan_550_packet_bin_loader.sv | 139 +++++++++++++
 4 files changed

// File: rtl/chan_550_packet_bin_loader_pkg.sv
// ---------------------------------------------------------------------------
// chan_550_packet_bin_loader_pkg
//   Shared definitions for the load_bins command loader: FSM state encoding,
//   command word strobe bit positions, counter widths and a saturating
//   increment helper.
// ---------------------------------------------------------------------------
package chan_550_packet_bin_loader_pkg;

  localparam int LOAD_BIT   = 31;
  localparam int CLR_BIT    = 30;

  localparam int LOAD_CNT_W = 16;
  localparam int ERR_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  function automatic logic [ERR_CNT_W-1:0] sat_inc_err(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/chan_550_packet_bin_loader_if.sv
// ---------------------------------------------------------------------------
// chan_550_packet_bin_loader_if
//   Write port into the channel->FFT-bin select table.
//   tbl_we   : one-cycle write enable
//   tbl_addr : channel address (ADDR_W)
//   tbl_data : FFT bin (BIN_W)
//   master = loader side (drives), slave = table RAM side (receives).
// ---------------------------------------------------------------------------
interface chan_550_packet_bin_loader_if
  import chan_550_packet_bin_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int BIN_W  = 10
);
  logic              tbl_we;
  logic [ADDR_W-1:0] tbl_addr;
  logic [BIN_W-1:0]  tbl_data;

  modport master (output tbl_we, output tbl_addr, output tbl_data);
  modport slave  (input  tbl_we, input  tbl_addr, input  tbl_data);
endinterface

// File: rtl/chan_550_packet_bin_loader_edge.sv
// ---------------------------------------------------------------------------
// chan_550_packet_bin_loader_edge
//   Samples the two command strobe bits (r1), keeps one cycle of history (r2)
//   and flags rising edges.
//   Ports: user_clk, user_rst_n (async active-low), strb_in[1:0] raw strobes,
//          rise[1:0] one-cycle rising-edge pulses.
//   A strobe already high when reset releases must not look like an edge, so
//   edges are masked until r2 holds a genuine sample (two clocks after reset).
// ---------------------------------------------------------------------------
module chan_550_packet_bin_loader_edge
  import chan_550_packet_bin_loader_pkg::*;
(
  input  logic       user_clk,
  input  logic       user_rst_n,
  input  logic [1:0] strb_in,
  output logic [1:0] rise
);

  logic [1:0] r1;
  logic [1:0] r2;
  logic [1:0] armed;

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r1    <= '0;
      r2    <= '0;
      armed <= '0;
    end else begin
      r1    <= strb_in;
      r2    <= r1;
      armed <= {armed[0], 1'b1};
    end
  end

  assign rise = {2{armed[1]}} & r1 & ~r2;

endmodule

// File: rtl/chan_550_packet_bin_loader.sv
// ---------------------------------------------------------------------------
// chan_550_packet_bin_loader
//   Turns load_bins register commands into writes on the channel->bin table.
//   LOAD rising edge  -> single validated write (chan, bin) from the word.
//   CLEAR rising edge -> writes 0 to every table address, 0..2**ADDR_W-1.
//
//   Ports:
//     user_clk, user_rst_n  clock, async active-low reset
//     load_word[31:0]       [31]=LOAD [30]=CLEAR [BIN_W+:ADDR_W]=chan [BIN_W-1:0]=bin
//     tbl (master)          table write port (tbl_we/tbl_addr/tbl_data)
//     busy                  command in progress
//     load_count[15:0]      accepted LOADs, wraps
//     err_count[7:0]        rejected LOADs (bin >= NUM_BINS), saturates
//     overrun               sticky, a strobe edge arrived while busy
//     status_word[31:0]     only with CHAN_550_PACKET_BIN_LOADER_STATUS_EN:
//                           registered {busy, overrun, 6'b0, err_count, load_count}
//
//   state  | meaning
//   IDLE   | waiting for a strobe edge
//   WRITE  | one cycle: validate bin, issue the single write or count error
//   CLEAR  | sweep addresses 0..2**ADDR_W-1 writing 0
// ---------------------------------------------------------------------------
module chan_550_packet_bin_loader
  import chan_550_packet_bin_loader_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int BIN_W    = 10,
  parameter int NUM_BINS = 512
) (
  input  logic                  user_clk,
  input  logic                  user_rst_n,
  input  logic [31:0]           load_word,
  chan_550_packet_bin_loader_if.master tbl,
  output logic                  busy,
  output logic [LOAD_CNT_W-1:0] load_count,
  output logic [ERR_CNT_W-1:0]  err_count,
`ifdef CHAN_550_PACKET_BIN_LOADER_STATUS_EN
  output logic [31:0]           status_word,
`endif
  output logic                  overrun
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_WRITE = ST_WRITE;
  localparam logic [1:0] S_CLEAR = ST_CLEAR;

  logic [1:0]        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] r1_chan;
  logic [BIN_W-1:0]  r1_bin;
  logic [1:0]        rise;
  logic              rise_load;
  logic              rise_clr;
  logic              bin_ok;
  logic              unused_word_bits;

  // Only the strobe and field bits matter; the rest of the word is ignored.
  assign unused_word_bits = ^load_word;

  chan_550_packet_bin_loader_edge u_edge (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .strb_in    ({load_word[LOAD_BIT], load_word[CLR_BIT]}),
    .rise       (rise)
  );

  assign rise_load = rise[1];
  assign rise_clr  = rise[0];

  // Field copy aligned with the strobe sample taken inside u_edge.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r1_chan <= '0;
      r1_bin  <= '0;
    end else begin
      r1_chan <= load_word[BIN_W +: ADDR_W];
      r1_bin  <= load_word[BIN_W-1:0];
    end
  end

  assign bin_ok = (int'(r1_bin) < NUM_BINS);
  assign busy   = (state != S_IDLE);

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state        <= S_IDLE;
      clr_cnt      <= '0;
      tbl.tbl_we   <= 1'b0;
      tbl.tbl_addr <= '0;
      tbl.tbl_data <= '0;
      load_count   <= '0;
      err_count    <= '0;
      overrun      <= 1'b0;
    end else begin
      tbl.tbl_we <= 1'b0;

      case (state)
        S_IDLE: begin
          // CLEAR takes priority; a LOAD edge in the same cycle is discarded.
          if (rise_clr) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
          end else if (rise_load) begin
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (bin_ok) begin
            tbl.tbl_we   <= 1'b1;
            tbl.tbl_addr <= r1_chan;
            tbl.tbl_data <= r1_bin;
            load_count   <= load_count + LOAD_CNT_W'(1);
          end else begin
            err_count <= sat_inc_err(err_count);
          end
          state <= S_IDLE;
        end
        S_CLEAR: begin
          tbl.tbl_we   <= 1'b1;
          tbl.tbl_addr <= clr_cnt;
          tbl.tbl_data <= '0;
          clr_cnt      <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == '1) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (busy && (rise_load || rise_clr)) overrun <= 1'b1;
    end
  end

`ifdef CHAN_550_PACKET_BIN_LOADER_STATUS_EN
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) status_word <= '0;
    else             status_word <= {busy, overrun, 6'b0, err_count, load_count};
  end
`endif

endmodule
